mc_controller: RTL and testbench

Multicycle sequencing controller for the MIPS core. It replaces the single-cycle combinational decoder with a Moore state machine, so one shared ALU and one unified instruction/data memory can execute each instruction over 3–5 cycles. It sits between the instruction register (op/funct) and the multicycle datapath, and drives every register/PC/IR/memory enable and mux select. Opcodes supported: R-type, LW, SW, BEQ, BNE, ADDI, J, ORI.

---
 rtl/mc_controller_if.sv | 50 +++++
 rtl/mc_controller.sv | 278 +++++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// mc_controller_if: control bus between the multicycle sequencer and the datapath.
//   master : sequencer side (reads op/funct/zero/memready, drives all controls)
//   slave  : datapath side (drives op/funct/zero/memready, reads all controls)
// Signals:
//   op[5:0], funct[5:0]  instruction fields from the instruction register
//   zero                 ALU zero flag
//   memready             memory done handshake (only honoured with MC_MEMWAIT_EN)
//   pcen, irwrite, memwrite, regwrite       write enables
//   iord, memtoreg, regdst, alusrca, immzext, alusrcb[1:0], pcsrc[1:0]  mux selects
//   alucontrol[3:0]      ALU operation
//   state[3:0]           current sequencer state (debug)
//   illegal              pulse on an undecodable instruction
interface mc_controller_if;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUC_W  = 4;
  localparam int unsigned STATE_W = 4;

  logic [OP_W-1:0]    op;
  logic [FUNCT_W-1:0] funct;
  logic               zero;
  logic               memready;

  logic               pcen;
  logic               irwrite;
  logic               memwrite;
  logic               regwrite;
  logic               iord;
  logic               memtoreg;
  logic               regdst;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic               immzext;
  logic [1:0]         pcsrc;
  logic [ALUC_W-1:0]  alucontrol;
  logic [STATE_W-1:0] state;
  logic               illegal;

  modport master (
    input  op, funct, zero, memready,
    output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, immzext, pcsrc, alucontrol, state, illegal
  );

  modport slave (
    output op, funct, zero, memready,
    input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, immzext, pcsrc, alucontrol, state, illegal
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: Moore sequencer for the multicycle MIPS datapath.
// Executes R-type, LW, SW, BEQ, BNE, ADDI, J and ORI over 3-5 cycles using a
// shared ALU and a unified instruction/data memory.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; returns the sequencer to FETCH
//   bus    mc_controller_if.master (instruction fields in, datapath controls out)
// Build option:
//   MC_MEMWAIT_EN  when defined, FETCH/MEMRD/MEMWR stall while memready=0;
//                  when undefined, memready is ignored and every state is 1 cycle.
// Controls are combinational from the state register (plus op/funct/zero/memready),
// so they line up with the datapath registers they enable in the same cycle.
module mc_controller (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUC_W  = 4;

  // State encoding
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_IMMWB   = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_ORIEX   = 4'd12;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

  // R-type function codes
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_XOR = 6'b100110;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  // ALU operations
  localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_AND = 4'b0100;
  localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0101;
  localparam logic [ALUC_W-1:0] ALU_XOR = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_NOR = 4'b0111;
  localparam logic [ALUC_W-1:0] ALU_SLT = 4'b1010;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  logic               pcwrite;
  logic               branch;
  logic               taken;
  logic               irwrite_raw;
  logic               memwrite_raw;
  logic               regwrite_raw;
  logic               illegal_raw;
  logic               iord;
  logic               memtoreg;
  logic               regdst;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic               immzext;
  logic [1:0]         pcsrc;
  logic [ALUC_W-1:0]  alucontrol;

  logic [ALUC_W-1:0]  funct_alu;
  logic               funct_ok;
  logic               mem_go;

`ifdef MC_MEMWAIT_EN
  assign mem_go = bus.memready;
`else
  // Memory is assumed single-cycle; memready is intentionally unused.
  logic unused_memready;
  assign unused_memready = bus.memready;
  assign mem_go          = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // R-type funct to ALU operation; funct_ok flags the supported subset
  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (bus.funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_XOR:  funct_alu = ALU_XOR;
      FN_NOR:  funct_alu = ALU_NOR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // BNE branches on a non-zero difference, BEQ on zero
  assign taken = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;

  // Next state and per-state controls
  always_comb begin
    state_d      = state_q;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    immzext      = 1'b0;
    pcsrc        = 2'b00;
    alucontrol   = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        // IR load and PC+4 only on the cycle memory delivers the word
        if (mem_go) begin
          irwrite_raw = 1'b1;
          pcwrite     = 1'b1;
          state_d     = S_DECODE;
        end
      end

      S_DECODE: begin
        // Precompute branch target into ALUOut
        alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_ORI:  state_d = S_ORIEX;
          OP_J:    state_d = S_JUMP;
          OP_RTYPE: begin
            if (funct_ok) begin
              state_d = S_EXECUTE;
            end else begin
              illegal_raw = 1'b1;
              state_d     = S_FETCH;
            end
          end
          default: begin
            illegal_raw = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (bus.op)
          OP_LW:   state_d = S_MEMRD;
          OP_SW:   state_d = S_MEMWR;
          default: state_d = S_FETCH;
        endcase
      end

      S_MEMRD: begin
        iord = 1'b1;
        if (mem_go) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEMWR: begin
        // Strobe held for the whole residency while memory is busy
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        if (mem_go) begin
          state_d = S_FETCH;
        end
      end

      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        state_d    = S_ALUWB;
      end

      S_ALUWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
        state_d      = S_FETCH;
      end

      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end

      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_IMMWB;
      end

      S_IMMWB: begin
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end

      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        state_d = S_FETCH;
      end

      S_ORIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        immzext    = 1'b1;
        alucontrol = ALU_OR;
        state_d    = S_IMMWB;
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Write enables and the illegal pulse are suppressed during reset so an
  // aborted instruction never commits anything.
  assign bus.pcen       = ~reset & (pcwrite | (branch & taken));
  assign bus.irwrite    = ~reset & irwrite_raw;
  assign bus.memwrite   = ~reset & memwrite_raw;
  assign bus.regwrite   = ~reset & regwrite_raw;
  assign bus.illegal    = ~reset & illegal_raw;
  assign bus.iord       = iord;
  assign bus.memtoreg   = memtoreg;
  assign bus.regdst     = regdst;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.immzext    = immzext;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed self-checking bench for mc_controller.
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge. Each test task starts just after a rising edge in FETCH.
module tb_mc_controller;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.op       = OP_LW;
    bus.funct    = 6'd0;
    bus.zero     = 1'b0;
    bus.memready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.pcen !== 1'b0) begin
      errors++; $display("FAIL reset_pcen got %b exp 0", bus.pcen);
    end
    checks++;
    if (bus.irwrite !== 1'b0) begin
      errors++; $display("FAIL reset_irwrite got %b exp 0", bus.irwrite);
    end
    checks++;
    if (bus.regwrite !== 1'b0 || bus.memwrite !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++; $display("FAIL reset_writes got rw=%b mw=%b il=%b exp 0", bus.regwrite, bus.memwrite, bus.illegal);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd0) begin
      errors++; $display("FAIL reset_state0 got %0d exp 0", bus.state);
    end
    checks++;
    if (bus.pcen !== 1'b1 || bus.irwrite !== 1'b1) begin
      errors++; $display("FAIL reset_fetch_en got pcen=%b ir=%b exp 1 1", bus.pcen, bus.irwrite);
    end
    checks++;
    if (bus.alusrcb !== 2'b01 || bus.alucontrol !== 4'b0000) begin
      errors++; $display("FAIL reset_fetch_alu got srcb=%b aluc=%b exp 01 0000", bus.alusrcb, bus.alucontrol);
    end
    next_cycle();
    checks++;
    if (bus.state !== 4'd1) begin
      errors++; $display("FAIL reset_state1 got %0d exp 1", bus.state);
    end
    // Let the LW finish so the next task starts in FETCH
    repeat (4) next_cycle();
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    bus.op = OP_LW;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== exp_st[i]) begin
        errors++; $display("FAIL lw_state cyc %0d got %0d exp %0d", i, bus.state, exp_st[i]);
      end
      checks++;
      if (bus.regwrite !== (i == 4) || bus.memtoreg !== (i == 4)) begin
        errors++; $display("FAIL lw_wb cyc %0d got rw=%b m2r=%b exp %b", i, bus.regwrite, bus.memtoreg, (i == 4));
      end
      checks++;
      if (bus.iord !== (i == 3) || bus.pcen !== (i == 0)) begin
        errors++; $display("FAIL lw_ctl cyc %0d got iord=%b pcen=%b", i, bus.iord, bus.pcen);
      end
      next_cycle();
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    bus.op = OP_SW;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== exp_st[i]) begin
        errors++; $display("FAIL sw_state cyc %0d got %0d exp %0d", i, bus.state, exp_st[i]);
      end
      checks++;
      if (bus.memwrite !== (i == 3) || bus.regwrite !== 1'b0) begin
        errors++; $display("FAIL sw_write cyc %0d got mw=%b rw=%b", i, bus.memwrite, bus.regwrite);
      end
      if (i == 2) begin
        checks++;
        if (bus.alusrca !== 1'b1 || bus.alusrcb !== 2'b10) begin
          errors++; $display("FAIL sw_memadr got a=%b b=%b exp 1 10", bus.alusrca, bus.alusrcb);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z, input logic exp_pcen);
    logic [3:0] exp_st [3] = '{4'd0, 4'd1, 4'd8};
    bus.op   = op;
    bus.zero = z;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== exp_st[i]) begin
        errors++; $display("FAIL br_state op=%b cyc %0d got %0d exp %0d", op, i, bus.state, exp_st[i]);
      end
      if (i == 1) begin
        checks++;
        if (bus.alusrcb !== 2'b11) begin
          errors++; $display("FAIL br_decode_srcb got %b exp 11", bus.alusrcb);
        end
      end
      if (i == 2) begin
        checks++;
        if (bus.pcen !== exp_pcen) begin
          errors++; $display("FAIL br_pcen op=%b z=%b got %b exp %b", op, z, bus.pcen, exp_pcen);
        end
        checks++;
        if (bus.pcsrc !== 2'b01 || bus.alucontrol !== 4'b0010 || bus.alusrca !== 1'b1) begin
          errors++; $display("FAIL br_ctl got pcsrc=%b aluc=%b a=%b exp 01 0010 1", bus.pcsrc, bus.alucontrol, bus.alusrca);
        end
      end
      next_cycle();
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [3:0] exp_alu);
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    bus.op    = OP_RTYPE;
    bus.funct = fn;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== exp_st[i]) begin
        errors++; $display("FAIL r_state fn=%b cyc %0d got %0d exp %0d", fn, i, bus.state, exp_st[i]);
      end
      if (i == 2) begin
        checks++;
        if (bus.alucontrol !== exp_alu || bus.alusrca !== 1'b1 || bus.regwrite !== 1'b0) begin
          errors++; $display("FAIL r_exec fn=%b got aluc=%b a=%b rw=%b exp %b 1 0", fn, bus.alucontrol, bus.alusrca, bus.regwrite, exp_alu);
        end
      end
      if (i == 3) begin
        checks++;
        if (bus.regwrite !== 1'b1 || bus.regdst !== 1'b1 || bus.memtoreg !== 1'b0) begin
          errors++; $display("FAIL r_wb got rw=%b rd=%b m2r=%b exp 1 1 0", bus.regwrite, bus.regdst, bus.memtoreg);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
    bus.op    = op;
    bus.funct = fn;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== 4'(i % 2)) begin
        errors++; $display("FAIL ill_state op=%b fn=%b cyc %0d got %0d exp %0d", op, fn, i, bus.state, i % 2);
      end
      checks++;
      if (bus.illegal !== (i == 1) || bus.regwrite !== 1'b0 || bus.memwrite !== 1'b0) begin
        errors++; $display("FAIL ill_flag cyc %0d got il=%b rw=%b mw=%b exp %b 0 0", i, bus.illegal, bus.regwrite, bus.memwrite, (i == 1));
      end
      next_cycle();
    end
    // Third cycle above was the next FETCH; finish its decode as a J
    bus.op = OP_J;
    repeat (2) next_cycle();
  endtask

  task automatic test_imm(input logic [5:0] op);
    logic [3:0] exec_st;
    logic [3:0] exp_st [4];
    exec_st = (op == OP_ORI) ? 4'd12 : 4'd9;
    exp_st  = '{4'd0, 4'd1, exec_st, 4'd10};
    bus.op  = op;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== exp_st[i]) begin
        errors++; $display("FAIL imm_state op=%b cyc %0d got %0d exp %0d", op, i, bus.state, exp_st[i]);
      end
      if (i == 2) begin
        checks++;
        if (bus.immzext !== (op == OP_ORI) || bus.alucontrol !== ((op == OP_ORI) ? 4'b0101 : 4'b0000)
            || bus.alusrcb !== 2'b10) begin
          errors++; $display("FAIL imm_exec op=%b got zx=%b aluc=%b b=%b", op, bus.immzext, bus.alucontrol, bus.alusrcb);
        end
      end
      checks++;
      if (bus.regwrite !== (i == 3) || (i == 3 && bus.regdst !== 1'b0)) begin
        errors++; $display("FAIL imm_wb cyc %0d got rw=%b rd=%b", i, bus.regwrite, bus.regdst);
      end
      next_cycle();
    end
  endtask

  task automatic test_jump();
    bus.op = OP_J;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd11 || bus.pcen !== 1'b1 || bus.pcsrc !== 2'b10) begin
      errors++; $display("FAIL jump got st=%0d pcen=%b pcsrc=%b exp 11 1 10", bus.state, bus.pcen, bus.pcsrc);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    bool_loop: begin end
    bus.op = OP_ORI;
    repeat (2) next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd12 || bus.regwrite !== 1'b0) begin
      errors++; $display("FAIL rmid_pre got st=%0d rw=%b exp 12 0", bus.state, bus.regwrite);
    end
    next_cycle();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.regwrite !== 1'b0) begin
      errors++; $display("FAIL rmid_abort got st=%0d rw=%b exp 0 0", bus.state, bus.regwrite);
    end
    bus.op = OP_J;
    repeat (3) next_cycle();
  endtask

`ifdef MC_MEMWAIT_EN
  task automatic test_fetch_wait();
    bus.op       = OP_J;
    bus.memready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== 4'd0 || bus.pcen !== 1'b0 || bus.irwrite !== 1'b0) begin
        errors++; $display("FAIL fwait cyc %0d got st=%0d pcen=%b ir=%b exp 0 0 0", i, bus.state, bus.pcen, bus.irwrite);
      end
      next_cycle();
    end
    bus.memready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd0 || bus.pcen !== 1'b1 || bus.irwrite !== 1'b1) begin
      errors++; $display("FAIL fwait_go got st=%0d pcen=%b ir=%b exp 0 1 1", bus.state, bus.pcen, bus.irwrite);
    end
    next_cycle();
    checks++;
    if (bus.state !== 4'd1) begin
      errors++; $display("FAIL fwait_decode got %0d exp 1", bus.state);
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_sw_wait();
    bus.op = OP_SW;
    repeat (3) next_cycle();
    bus.memready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.memready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.state !== 4'd5 || bus.memwrite !== 1'b1) begin
        errors++; $display("FAIL swwait cyc %0d got st=%0d mw=%b exp 5 1", i, bus.state, bus.memwrite);
      end
      next_cycle();
    end
    checks++;
    if (bus.state !== 4'd0 || bus.memwrite !== 1'b0) begin
      errors++; $display("FAIL swwait_done got st=%0d mw=%b exp 0 0", bus.state, bus.memwrite);
    end
  endtask
`else
  task automatic test_memready_ignored();
    logic [3:0] exp_st [3] = '{4'd0, 4'd1, 4'd11};
    bus.op       = OP_J;
    bus.memready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== exp_st[i] || bus.pcen !== (i != 1)) begin
        errors++; $display("FAIL noready cyc %0d got st=%0d pcen=%b exp %0d %b", i, bus.state, bus.pcen, exp_st[i], (i != 1));
      end
      next_cycle();
    end
    bus.memready = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lw();
    test_sw();
    test_branch(OP_BNE, 1'b0, 1'b1);
    test_branch(OP_BNE, 1'b1, 1'b0);
    test_branch(OP_BEQ, 1'b0, 1'b0);
    test_branch(OP_BEQ, 1'b1, 1'b1);
    test_rtype(6'b100111, 4'b0111);
    test_rtype(6'b101010, 4'b1010);
    test_rtype(6'b100010, 4'b0010);
    test_illegal(OP_RTYPE, 6'b000001);
    test_illegal(6'b111111, 6'b100000);
    test_imm(OP_ORI);
    test_imm(OP_ADDI);
    test_jump();
    test_reset_mid();
`ifdef MC_MEMWAIT_EN
    test_fetch_wait();
    test_sw_wait();
`else
    test_memready_ignored();
`endif
    // Back-to-back instructions should leave the sequencer in FETCH
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd0) begin
      errors++; $display("FAIL final_state got %0d exp 0", bus.state);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
